// File: rtl/gf256_inv_pipe.sv
// Multi-lane pipelined GF(2^8) inverter in the GF((2^4)^2) composite basis, with a valid/ready handshake.
// Define GF256_INV_ZERO_FLAG_EN to add the per-lane out_zero flag that travels with the data.

module gf256_inv_lane #(
    parameter int PIPE_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIPE_STAGES-1:0] i_en,
    input  logic [7:0]             i_byte,
    output logic [7:0]             o_byte
`ifdef GF256_INV_ZERO_FLAG_EN
    ,
    output logic                   o_zero
`endif
);

    // GF(2^4) multiply, reduction polynomial x^4+x+1
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;  4'h4: r = 4'hD;
            4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;  4'h8: r = 4'hF;
            4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;  4'hC: r = 4'hA;
            4'hD: r = 4'h4;  4'hE: r = 4'h3;  4'hF: r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // Partials are packed {sh, t, d} before the inverse and {sh, t, e} after it
    function automatic logic [11:0] f_d(input logic [7:0] b);
        logic [3:0] sh;
        logic [3:0] t;
        sh = b[7:4];
        t  = b[7:4] ^ b[3:0];
        return {sh, t, gf4_mul(4'hC, gf4_mul(sh, sh)) ^ gf4_mul(b[3:0], t)};
    endfunction

    function automatic logic [11:0] f_e(input logic [11:0] p);
        return {p[11:4], gf4_inv(p[3:0])};
    endfunction

    function automatic logic [7:0] f_out(input logic [11:0] p);
        return {gf4_mul(p[3:0], p[11:8]), gf4_mul(p[3:0], p[7:4])};
    endfunction

    logic [11:0] w_p1;
    logic [7:0]  r_out;

    assign w_p1   = f_d(i_byte);
    assign o_byte = r_out;

    generate
        if (PIPE_STAGES == 1) begin : g_p1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       r_out <= '0;
                else if (i_en[0]) r_out <= f_out(f_e(w_p1));
            end
        end else if (PIPE_STAGES == 2) begin : g_p2
            logic [11:0] r_s0;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s0  <= '0;
                    r_out <= '0;
                end else begin
                    if (i_en[0]) r_s0  <= w_p1;
                    if (i_en[1]) r_out <= f_out(f_e(r_s0));
                end
            end
        end else begin : g_p3
            logic [11:0] r_s0;
            logic [11:0] r_s1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s0  <= '0;
                    r_s1  <= '0;
                    r_out <= '0;
                end else begin
                    if (i_en[0]) r_s0  <= w_p1;
                    if (i_en[1]) r_s1  <= f_e(r_s0);
                    if (i_en[2]) r_out <= f_out(r_s1);
                end
            end
        end
    endgenerate

`ifdef GF256_INV_ZERO_FLAG_EN
    logic [PIPE_STAGES-1:0] r_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z <= '0;
        end else begin
            if (i_en[0]) r_z[0] <= (i_byte == 8'h00);
            for (int k = 1; k < PIPE_STAGES; k++)
                if (i_en[k]) r_z[k] <= r_z[k-1];
        end
    end

    assign o_zero = r_z[PIPE_STAGES-1];
`endif

endmodule

module gf256_inv_pipe #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag
`ifdef GF256_INV_ZERO_FLAG_EN
    ,
    output logic [LANES-1:0]     out_zero
`endif
);

    logic [PIPE_STAGES-1:0]            r_vld_pipe;
    logic [PIPE_STAGES-1:0][TAG_W-1:0] r_tag;
    logic [PIPE_STAGES-1:0]            w_ld;
    logic [PIPE_STAGES-1:0]            w_en;

    // A stage can load if it is empty or the stage after it can load too;
    // this lets a bubble anywhere be filled while the output is stalled.
    always_comb begin : p_ld
        logic w_dn;
        w_ld = '0;
        w_dn = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            w_ld[k] = !r_vld_pipe[k] || w_dn;
            w_dn    = w_ld[k];
        end
    end

    assign in_ready = w_ld[0] && !flush;

    always_comb begin
        w_en    = '0;
        w_en[0] = in_valid && in_ready;
        for (int k = 1; k < PIPE_STAGES; k++)
            w_en[k] = w_ld[k] && r_vld_pipe[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_tag      <= '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (flush)        r_vld_pipe[k] <= 1'b0;
                else if (w_ld[k]) r_vld_pipe[k] <= w_en[k];
            end
            if (w_en[0]) r_tag[0] <= in_tag;
            for (int k = 1; k < PIPE_STAGES; k++)
                if (w_en[k]) r_tag[k] <= r_tag[k-1];
        end
    end

    assign out_valid = r_vld_pipe[PIPE_STAGES-1];
    assign out_tag   = r_tag[PIPE_STAGES-1];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gf256_inv_lane #(
            .PIPE_STAGES (PIPE_STAGES)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_en),
            .i_byte (in_data[8*i +: 8]),
            .o_byte (out_data[8*i +: 8])
`ifdef GF256_INV_ZERO_FLAG_EN
            ,
            .o_zero (out_zero[i])
`endif
        );
    end

endmodule

// File: doc/gf256_inv_pipe.md
Name: gf256_inv_pipe

Overview:
- Multi-lane, pipelined GF(2^8) multiplicative inverter for the AES S-box datapath.
- Uses the composite-field GF((2^4)^2) representation; each lane computes one inverse per cycle.
- Has a valid/ready handshake, a sideband tag, and bubble-collapsing stall handling.
- Sits between the S-box input isomorphism map and the output affine/inverse-map logic; replaces the single-lane combinational inverter.

Parameters:
- LANES, 4, number of independent byte lanes processed per transfer (1..16).
- PIPE_STAGES, 2, number of register stages (1..3); equals latency in cycles with no stall.
- TAG_W, 4, width of the sideband tag carried alongside the data (1..16).

Ports:
- clk  in  1  single clock; all registers rise-edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; clears all stage valids next edge.
- in_valid  in  1  input transfer valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  8*LANES  lane i at bits [8i+7:8i]; composite-basis bytes, high nibble = sh, low nibble = sl.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8*LANES  inverse per lane, same basis and lane order as in_data.
- out_tag  out  TAG_W  tag of the corresponding input.

Behaviour:
- Arithmetic, per lane:
  - GF(2^4) reduction polynomial is x^4+x+1; extension polynomial is y^2+y+lambda with lambda = 4'hC.
  - sh = byte[7:4], sl = byte[3:0], t = sh^sl.
  - d = lambda*sh^2 ^ sl*t; e = d^-1 in GF(2^4), with 0^-1 defined as 0.
  - result = {e*sh, e*t}. Input 8'h00 gives 8'h00.
- Stage split:
  - PIPE_STAGES=1: a single output register.
  - PIPE_STAGES=2: register after d; register at the output.
  - PIPE_STAGES=3: register after d; register after e (sh and t carried forward); register at the output.
- Each stage holds a valid bit, the lane data/partials, and the tag.
- Stage k loads when it is empty, or when its contents move on in the same cycle.
- The last stage moves on when out_valid && out_ready.
- in_ready = stage 0 can load (combinational path from out_ready allowed).
- An input is accepted when in_valid && in_ready.
- Throughput is 1 transfer/cycle while out_ready=1. A bubble in any stage is filled even while the output is stalled.
- out_valid = last-stage valid. out_data and out_tag hold stable while out_valid && !out_ready.
- Results leave in acceptance order; tags never separate from their data.
- Reset (rst_n=0, async): all valids 0, out_valid=0, out_data=0, out_tag=0, in_ready=1 after release. In-flight transfers are discarded.
- flush=1:
  - All valids clear at the next edge.
  - An input offered in the same cycle is not accepted (in_ready=0 while flush=1).
  - Data registers need not clear.
- Simultaneous out_ready and full pipeline: the pipeline shifts and accepts new input in the same cycle, with no bubble.
- in_valid low: stages drain normally; no spurious out_valid.

Optional Feature:
- Macro: GF256_INV_ZERO_FLAG_EN.
- Defined:
  - Adds output out_zero[LANES]; bit i = 1 when lane i's input byte was 8'h00.
  - Pipelined with the data, reset to 0, cleared validity by flush.
  - Used by fault/side-channel countermeasure logic.
- Undefined: the port is absent and there is no extra logic; all other behaviour is identical.

Test Plan:
- Single transfer, LANES=4, PIPE_STAGES=2, in_data=32'h10_01_00_10, tag=4'h5, out_ready=1 -> two cycles later out_valid=1, out_data=32'hAA_01_00_AA, out_tag=4'h5, for one cycle.
- Exhaustive involution: stream all 256 bytes back-to-back, feed each result back in -> second pass returns the original byte. Every result a!=0 satisfies a*inv(a)=1 in the reference model. Throughput 1/cycle.
- Backpressure: fill the pipeline with tags 1,2,3, out_ready=0 for 5 cycles -> out_data/out_tag stable (tag 1), in_ready=0 once all PIPE_STAGES stages are full. Release -> tags 1,2,3 emerge in order, no loss or duplication.
- Bubble collapse: PIPE_STAGES=3, alternating in_valid, out_ready=0 -> all 3 stages fill, then in_ready=0.
- Reset/flush mid-operation: 2 transfers in flight, assert rst_n=0 asynchronously (and separately flush=1 for 1 cycle) -> out_valid=0 immediately/next edge; no stale result is emitted after restart.
- With GF256_INV_ZERO_FLAG_EN: in_data=32'h00_37_00_01 -> out_zero=4'b1010 aligned with the result.
